// File: rtl/oursring_resp_arb_pkg.sv
// Shared types and helpers for the oursring response arbiter.
// The R/B response structs mirror the shared oursring interface typedefs.
package oursring_resp_arb_pkg;

    typedef struct packed {
        logic [3:0]  rid;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
    } oursring_resp_if_r_t;

    typedef struct packed {
        logic [3:0] bid;
        logic [1:0] bresp;
    } oursring_resp_if_b_t;

    localparam int RESP_R_W = $bits(oursring_resp_if_r_t);
    localparam int RESP_B_W = $bits(oursring_resp_if_b_t);

    // Width of a source index; a single source still gets a 1-bit field.
    function automatic int src_w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Candidate source 'off' positions after the last grant, wrapping at n.
    function automatic int rr_index(input int last, input int off, input int n);
        return (last + off) % n;
    endfunction

endpackage

// File: rtl/oursring_resp_arb_rr_arb.sv
// Round-robin arbiter with a one-deep registered output slot.
// Holds the last-grant pointer, picks the next requester after it and
// captures the winning payload together with its source index.
module oursring_rr_arb
    import oursring_resp_arb_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int WIDTH = 8,
    localparam int SRC_W = src_w_of(N_SRC)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [N_SRC-1:0][WIDTH-1:0] i_data,
    input  logic [N_SRC-1:0]            i_valid,
    output logic [N_SRC-1:0]            i_ready,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [SRC_W-1:0]            o_src
);

    // Reset pointer at the last source so source 0 wins the first grant.
    localparam logic [SRC_W-1:0] PTR_RST = SRC_W'(N_SRC - 1);

    logic [SRC_W-1:0] ptr_r;
    logic [SRC_W-1:0] cand_s;
    logic [SRC_W-1:0] gidx_s;
    logic [N_SRC-1:0] grant_s;
    logic             found_s;
    logic             slot_free_s;
    logic             accept_s;

    // Search requesters starting just after the last grant; first hit wins.
    always_comb begin
        grant_s = '0;
        gidx_s  = '0;
        cand_s  = '0;
        found_s = 1'b0;
        for (int off = 1; off <= N_SRC; off++) begin
            cand_s = SRC_W'(rr_index(int'(ptr_r), off, N_SRC));
            if (!found_s && i_valid[cand_s]) begin
                grant_s[cand_s] = 1'b1;
                gidx_s          = cand_s;
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // The slot can take a beat when empty or when its beat leaves this cycle;
    // o_ready only reaches the source-side ready, never o_valid.
    always_comb begin
        slot_free_s = !o_valid || o_ready;
        accept_s    = found_s && slot_free_s;
        i_ready     = grant_s & {N_SRC{slot_free_s}};
    end

    // Output slot and pointer: load on accept, empty on drain, hold on stall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r   <= PTR_RST;
            o_valid <= 1'b0;
            o_src   <= '0;
            o_data  <= '0;
        end else if (accept_s) begin
            ptr_r   <= gidx_s;
            o_valid <= 1'b1;
            o_src   <= gidx_s;
            o_data  <= i_data[gidx_s];
        end else if (slot_free_s) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= o_valid;
        end
    end

endmodule

// File: rtl/oursring_resp_arb.sv
// Merges N_SRC oursring response sources onto one response interface.
// R and B channels are arbitrated by two independent round-robin slots.
module oursring_resp_arb
    import oursring_resp_arb_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SRC_W = src_w_of(N_SRC)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_SRC-1:0][RESP_R_W-1:0] i_resp_if_r,
    input  logic [N_SRC-1:0]               i_resp_if_rvalid,
    output logic [N_SRC-1:0]               i_resp_if_rready,
    input  logic [N_SRC-1:0][RESP_B_W-1:0] i_resp_if_b,
    input  logic [N_SRC-1:0]               i_resp_if_bvalid,
    output logic [N_SRC-1:0]               i_resp_if_bready,
    output logic [RESP_R_W-1:0]            o_resp_if_r,
    output logic                           o_resp_if_rvalid,
    input  logic                           o_resp_if_rready,
    output logic [SRC_W-1:0]               o_resp_if_r_src,
    output logic [RESP_B_W-1:0]            o_resp_if_b,
    output logic                           o_resp_if_bvalid,
    input  logic                           o_resp_if_bready,
    output logic [SRC_W-1:0]               o_resp_if_b_src
);

    oursring_rr_arb #(
        .N_SRC (N_SRC),
        .WIDTH (RESP_R_W)
    ) u_r_arb (
        .clk     (clk),
        .rstn    (rstn),
        .i_data  (i_resp_if_r),
        .i_valid (i_resp_if_rvalid),
        .i_ready (i_resp_if_rready),
        .o_data  (o_resp_if_r),
        .o_valid (o_resp_if_rvalid),
        .o_ready (o_resp_if_rready),
        .o_src   (o_resp_if_r_src)
    );

    oursring_rr_arb #(
        .N_SRC (N_SRC),
        .WIDTH (RESP_B_W)
    ) u_b_arb (
        .clk     (clk),
        .rstn    (rstn),
        .i_data  (i_resp_if_b),
        .i_valid (i_resp_if_bvalid),
        .i_ready (i_resp_if_bready),
        .o_data  (o_resp_if_b),
        .o_valid (o_resp_if_bvalid),
        .o_ready (o_resp_if_bready),
        .o_src   (o_resp_if_b_src)
    );

endmodule

// File: tb/tb_oursring_resp_arb.sv
// Scoreboard bench for oursring_resp_arb (4-source build plus a 1-source build).
module tb_oursring_resp_arb;
    import oursring_resp_arb_pkg::*;

    localparam int N  = 4;
    localparam int RW = RESP_R_W;
    localparam int BW = RESP_B_W;

    typedef struct { int src; logic [RW-1:0] data; } r_exp_t;
    typedef struct { int src; logic [BW-1:0] data; } b_exp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // 4-source DUT signals
    logic [N-1:0][RW-1:0] i_r;
    logic [N-1:0][BW-1:0] i_b;
    logic [N-1:0]         i_rvalid, i_rready, i_bvalid, i_bready;
    logic [RW-1:0]        o_r;
    logic [BW-1:0]        o_b;
    logic                 o_rvalid, o_rready, o_bvalid, o_bready;
    logic [1:0]           o_r_src, o_b_src;

    // 1-source DUT signals
    logic [0:0][RW-1:0] i_r1;
    logic [0:0][BW-1:0] i_b1;
    logic [0:0]         i_rvalid1, i_rready1, i_bvalid1, i_bready1;
    logic [RW-1:0]      o_r1;
    logic [BW-1:0]      o_b1;
    logic               o_rvalid1, o_bvalid1, o_bready1;
    logic [0:0]         o_r_src1, o_b_src1;

    // Source-side stimulus state
    logic [N-1:0]  r_pend, b_pend;
    logic [RW-1:0] r_pay [N];
    logic [BW-1:0] b_pay [N];
    logic          b1_pend;
    logic [BW-1:0] b1_pay;

    // Reference model state
    int  m_r_ptr, m_b_ptr;
    logic m_r_full, m_b_full, m1_full;
    r_exp_t r_q[$];
    b_exp_t b_q[$];
    logic [BW-1:0] q1[$];
    int n1_seen;

    int vectors = 0;
    int miscompares = 0;

    assign i_rvalid  = r_pend;
    assign i_bvalid  = b_pend;
    assign i_rvalid1 = 1'b0;
    assign i_bvalid1 = b1_pend;
    always_comb begin
        for (int k = 0; k < N; k++) begin
            i_r[k] = r_pay[k];
            i_b[k] = b_pay[k];
        end
        i_r1[0] = '0;
        i_b1[0] = b1_pay;
    end

    oursring_resp_arb #(.N_SRC(N)) dut (
        .clk(clk), .rstn(rstn),
        .i_resp_if_r(i_r), .i_resp_if_rvalid(i_rvalid), .i_resp_if_rready(i_rready),
        .i_resp_if_b(i_b), .i_resp_if_bvalid(i_bvalid), .i_resp_if_bready(i_bready),
        .o_resp_if_r(o_r), .o_resp_if_rvalid(o_rvalid), .o_resp_if_rready(o_rready),
        .o_resp_if_r_src(o_r_src),
        .o_resp_if_b(o_b), .o_resp_if_bvalid(o_bvalid), .o_resp_if_bready(o_bready),
        .o_resp_if_b_src(o_b_src)
    );

    oursring_resp_arb #(.N_SRC(1)) dut1 (
        .clk(clk), .rstn(rstn),
        .i_resp_if_r(i_r1), .i_resp_if_rvalid(i_rvalid1), .i_resp_if_rready(i_rready1),
        .i_resp_if_b(i_b1), .i_resp_if_bvalid(i_bvalid1), .i_resp_if_bready(i_bready1),
        .o_resp_if_r(o_r1), .o_resp_if_rvalid(o_rvalid1), .o_resp_if_rready(1'b1),
        .o_resp_if_r_src(o_r_src1),
        .o_resp_if_b(o_b1), .o_resp_if_bvalid(o_bvalid1), .o_resp_if_bready(o_bready1),
        .o_resp_if_b_src(o_b_src1)
    );

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [RW-1:0] rand_r();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[RW-1:0];
    endfunction

    function automatic logic [BW-1:0] rand_b();
        logic [31:0] t;
        t = $urandom;
        return t[BW-1:0];
    endfunction

    // Round-robin rule: first requester after the last grant, wrapping.
    function automatic int rr_pick(input int last, input logic [N-1:0] req);
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (last + off) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    // Monitor: every beat leaving the 4-source DUT must match the queue head.
    always @(negedge clk) begin
        r_exp_t re;
        b_exp_t be;
        if (rstn === 1'b1) begin
            if (o_rvalid && o_rready) begin
                if (r_q.size() == 0) check("r_unexpected_beat", 128'd1, 128'd0);
                else begin
                    re = r_q.pop_front();
                    check("r_src", 128'(o_r_src), 128'(re.src));
                    check("r_data", 128'(o_r), 128'(re.data));
                end
            end
            if (o_bvalid && o_bready) begin
                if (b_q.size() == 0) check("b_unexpected_beat", 128'd1, 128'd0);
                else begin
                    be = b_q.pop_front();
                    check("b_src", 128'(o_b_src), 128'(be.src));
                    check("b_data", 128'(o_b), 128'(be.data));
                end
            end
        end
    end

    // Monitor: 1-source build B channel.
    always @(negedge clk) begin
        logic [BW-1:0] e1;
        if (rstn === 1'b1 && o_bvalid1 && o_bready1) begin
            n1_seen++;
            if (q1.size() == 0) check("n1_unexpected_beat", 128'd1, 128'd0);
            else begin
                e1 = q1.pop_front();
                check("n1_b_data", 128'(o_b1), 128'(e1));
                check("n1_b_src", 128'(o_b_src1), 128'd0);
            end
        end
    end

    // One cycle: model predicts handshakes, then new stimulus after the edge.
    // mode 0: no new requests, 1: random requests and readies, 2: keep all requesting.
    task automatic step(input int mode);
        int kr, kb;
        logic fr, fb;
        @(negedge clk);
        check("r_valid", 128'(o_rvalid), 128'(m_r_full));
        check("b_valid", 128'(o_bvalid), 128'(m_b_full));
        fr = !m_r_full || o_rready;
        fb = !m_b_full || o_bready;
        kr = rr_pick(m_r_ptr, r_pend);
        kb = rr_pick(m_b_ptr, b_pend);
        if (!fr) kr = -1;
        if (!fb) kb = -1;
        check("r_ready", 128'(i_rready), (kr >= 0) ? (128'd1 << kr) : 128'd0);
        check("b_ready", 128'(i_bready), (kb >= 0) ? (128'd1 << kb) : 128'd0);
        if (kr >= 0) begin r_q.push_back('{kr, r_pay[kr]}); m_r_ptr = kr; m_r_full = 1'b1; end
        else if (fr) m_r_full = 1'b0;
        if (kb >= 0) begin b_q.push_back('{kb, b_pay[kb]}); m_b_ptr = kb; m_b_full = 1'b1; end
        else if (fb) m_b_full = 1'b0;
        @(posedge clk);
        #1;
        if (kr >= 0) r_pend[kr] = 1'b0;
        if (kb >= 0) b_pend[kb] = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!r_pend[k] && (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1))) begin
                r_pay[k] = rand_r(); r_pend[k] = 1'b1;
            end
            if (!b_pend[k] && (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1))) begin
                b_pay[k] = rand_b(); b_pend[k] = 1'b1;
            end
        end
        if (mode == 1) begin
            o_rready = ($urandom_range(0, 3) != 0);
            o_bready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic clear_model();
        m_r_ptr = N - 1; m_b_ptr = N - 1;
        m_r_full = 1'b0; m_b_full = 1'b0;
        r_q.delete(); b_q.delete();
        r_pend = '0; b_pend = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rstn = 1'b0;
        clear_model();
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        logic [7:0] rdy_pat;
        int issued;
        logic free1, acc1;

        rstn = 1'b0;
        o_rready = 1'b0; o_bready = 1'b0; o_bready1 = 1'b0;
        b1_pend = 1'b0; b1_pay = '0; m1_full = 1'b0; n1_seen = 0;
        for (int k = 0; k < N; k++) begin r_pay[k] = '0; b_pay[k] = '0; end
        clear_model();

        // Reset values
        #12;
        check("rst_rvalid", 128'(o_rvalid), 128'd0);
        check("rst_r_src", 128'(o_r_src), 128'd0);
        check("rst_r", 128'(o_r), 128'd0);
        check("rst_bvalid", 128'(o_bvalid), 128'd0);
        check("rst_b_src", 128'(o_b_src), 128'd0);
        check("rst_b", 128'(o_b), 128'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single R request from source 2
        o_rready = 1'b1; o_bready = 1'b1;
        r_pay[2] = rand_r(); r_pend[2] = 1'b1;
        step(0);
        check("single_r_src", 128'(o_r_src), 128'd2);
        step(0);
        step(0);

        // All sources request continuously, one beat per cycle
        repeat (14) step(2);
        repeat (6) step(0);

        // Fresh reset: all sources request, source 0 first
        do_reset();
        r_pend = '1;
        for (int k = 0; k < N; k++) r_pay[k] = rand_r();
        step(0);
        check("post_reset_first_src", 128'(o_r_src), 128'd0);
        repeat (6) step(0);

        // Sources 1 and 3 with a 5-cycle stall after the first beat
        do_reset();
        r_pay[1] = rand_r(); r_pay[3] = rand_r(); r_pend[1] = 1'b1; r_pend[3] = 1'b1;
        o_rready = 1'b1;
        step(0);
        o_rready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(0);
            check("stall_src", 128'(o_r_src), 128'd1);
        end
        o_rready = 1'b1;
        step(0);
        check("after_stall_src", 128'(o_r_src), 128'd3);
        repeat (3) step(0);

        // Concurrent R and B from source 0
        r_pay[0] = rand_r(); r_pend[0] = 1'b1;
        b_pay[0] = rand_b(); b_pend[0] = 1'b1;
        step(0);
        check("conc_rvalid", 128'(o_rvalid), 128'd1);
        check("conc_bvalid", 128'(o_bvalid), 128'd1);
        check("conc_r_src", 128'(o_r_src), 128'd0);
        check("conc_b_src", 128'(o_b_src), 128'd0);
        repeat (3) step(0);

        // Asynchronous reset while a beat is stalled
        r_pay[1] = rand_r(); r_pend[1] = 1'b1;
        o_rready = 1'b0;
        step(0);
        check("pre_async_rvalid", 128'(o_rvalid), 128'd1);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_rvalid", 128'(o_rvalid), 128'd0);
        clear_model();
        @(posedge clk);
        #1 rstn = 1'b1;
        o_rready = 1'b1;
        r_pend = '1;
        for (int k = 0; k < N; k++) r_pay[k] = rand_r();
        step(0);
        check("async_rst_first_src", 128'(o_r_src), 128'd0);
        repeat (6) step(0);

        // Randomized traffic on both channels
        repeat (400) step(1);
        o_rready = 1'b1; o_bready = 1'b1;
        repeat (12) step(0);
        check("r_queue_empty", 128'(r_q.size()), 128'd0);
        check("b_queue_empty", 128'(b_q.size()), 128'd0);

        // 1-source build: three back-to-back B beats, bready 1,0,1,...
        rdy_pat = 8'b1110_1101;
        b1_pay = rand_b(); b1_pend = 1'b1; issued = 1;
        for (int c = 0; c < 12; c++) begin
            o_bready1 = rdy_pat[c % 8];
            @(negedge clk);
            check("n1_bvalid", 128'(o_bvalid1), 128'(m1_full));
            free1 = !m1_full || o_bready1;
            acc1 = b1_pend && free1;
            check("n1_bready", 128'(i_bready1), 128'(acc1));
            if (acc1) begin q1.push_back(b1_pay); m1_full = 1'b1; end
            else if (free1) m1_full = 1'b0;
            @(posedge clk);
            #1;
            if (acc1) begin
                if (issued < 3) begin b1_pay = rand_b(); issued++; end
                else b1_pend = 1'b0;
            end
        end
        check("n1_beats_delivered", 128'(n1_seen), 128'd3);
        check("n1_queue_empty", 128'(q1.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
